// File: rtl/trap_capture_pkg.sv
// Shared defines for the main-screen trap logic.
// Holds the frame-count defaults for the trap hold and post-release cooldown,
// the coordinate type shared by the trap mover and the ball override path,
// and a saturating increment for the capture counter.
package trap_capture_pkg;

  localparam int unsigned SCREEN_MAIN_TRAP_HOLD_FRAMES     = 60;
  localparam int unsigned SCREEN_MAIN_TRAP_COOLDOWN_FRAMES = 30;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned HITS_W  = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [HITS_W-1:0]  hits_t;

  // Capture count stops at its maximum instead of wrapping back to zero.
  function automatic hits_t sat_inc_hits(input hits_t value);
    hits_t result;
    if (value == 4'hF) begin
      result = value;
    end else begin
      result = value + 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/trap_capture_if.sv
// Trap position bus between the trap mover, the trap capture block and the
// ball renderer.
//   trapCenterX/Y : current trap centre, driven by the trap mover
//   lockX/Y       : ball position override, driven by the trap capture block
// master = trap mover / ball side, slave = trap capture block.
interface trap_capture_if;
  import trap_capture_pkg::*;

  coord_t trapCenterX;
  coord_t trapCenterY;
  coord_t lockX;
  coord_t lockY;

  modport master (
    output trapCenterX,
    output trapCenterY,
    input  lockX,
    input  lockY
  );

  modport slave (
    input  trapCenterX,
    input  trapCenterY,
    output lockX,
    output lockY
  );

endinterface

// File: rtl/trap_capture.sv
// Trap capture: when the ball overlaps the trap, the ball is held at the trap
// centre for HOLD_FRAMES frames, then released with a one-cycle lifeLost
// pulse, followed by COOLDOWN_FRAMES frames in which collisions are ignored.
// Ports:
//   clk          : system clock, rising edge
//   resetN       : asynchronous active-low reset
//   startOfFrame : one-cycle frame pulse
//   reset_level  : synchronous level restart, overrides every other input
//   pause        : freezes all progress while high (release still completes)
//   collision    : pixel-level ball/trap overlap, any cycle of the scan
//   trap_if      : trap centre in, ball lock position out
//   trapped      : high while the ball is held
//   lifeLost     : one-cycle pulse on release
//   trapHits     : saturating count of captures in the current level
module trap_capture
  import trap_capture_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES     = SCREEN_MAIN_TRAP_HOLD_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = SCREEN_MAIN_TRAP_COOLDOWN_FRAMES
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 reset_level,
  input  logic                 pause,
  input  logic                 collision,
  trap_capture_if.slave        trap_if,
  output logic                 trapped,
  output logic                 lifeLost,
  output logic [HITS_W-1:0]    trapHits
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    RELEASE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // The capture and cooldown frame pulses both count their last frame at
  // counter 0, so the load value is one less than the frame count.
  localparam logic [7:0] HOLD_LOAD     = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES - 1);

  state_t       state_r,     state_s;
  logic [7:0]   counter_r,   counter_s;
  logic         hit_latch_r, hit_latch_s;
  hits_t        hits_r,      hits_s;
  logic         trapped_r,   trapped_s;
  logic         lifelost_r,  lifelost_s;
  coord_t       lock_x_r,    lock_x_s;
  coord_t       lock_y_r,    lock_y_s;
  logic         frame_s;

  // Next-state, counter, hit latch, capture count and output decode.
  always_comb begin
    state_s     = state_r;
    counter_s   = counter_r;
    hit_latch_s = hit_latch_r;
    hits_s      = hits_r;
    frame_s     = startOfFrame & ~pause;

    if (reset_level) begin
      state_s     = IDLE;
      counter_s   = 8'd0;
      hit_latch_s = 1'b0;
      hits_s      = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pause) begin
            hit_latch_s = hit_latch_r;
          end else if (startOfFrame) begin
            // A collision seen anywhere in the finished frame, or on the
            // frame pulse itself, captures the ball.
            if (hit_latch_r || collision) begin
              state_s   = CAPTURED;
              counter_s = HOLD_LOAD;
              hits_s    = sat_inc_hits(hits_r);
            end else begin
              state_s = IDLE;
            end
            hit_latch_s = 1'b0;
          end else if (collision) begin
            hit_latch_s = 1'b1;
          end else begin
            hit_latch_s = hit_latch_r;
          end
        end

        CAPTURED: begin
          if (frame_s) begin
            if (counter_r == 8'd0) begin
              state_s = RELEASE;
            end else begin
              counter_s = counter_r - 8'd1;
            end
          end else begin
            counter_s = counter_r;
          end
        end

        // Lasts one cycle even while paused so the lifeLost pulse is never
        // swallowed.
        RELEASE: begin
          state_s   = COOLDOWN;
          counter_s = COOLDOWN_LOAD;
        end

        COOLDOWN: begin
          if (frame_s) begin
            if (counter_r == 8'd0) begin
              state_s = IDLE;
            end else begin
              counter_s = counter_r - 8'd1;
            end
          end else begin
            counter_s = counter_r;
          end
        end

        default: begin
          state_s     = IDLE;
          counter_s   = 8'd0;
          hit_latch_s = 1'b0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe. The lock position samples the trap
    // centre each cycle so a held ball follows a moving trap.
    trapped_s  = (state_s == CAPTURED);
    lifelost_s = (state_s == RELEASE);
    if (trapped_s) begin
      lock_x_s = trap_if.trapCenterX;
      lock_y_s = trap_if.trapCenterY;
    end else begin
      lock_x_s = {COORD_W{1'b0}};
      lock_y_s = {COORD_W{1'b0}};
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= IDLE;
      counter_r   <= 8'd0;
      hit_latch_r <= 1'b0;
      hits_r      <= 4'd0;
      trapped_r   <= 1'b0;
      lifelost_r  <= 1'b0;
      lock_x_r    <= {COORD_W{1'b0}};
      lock_y_r    <= {COORD_W{1'b0}};
    end else begin
      state_r     <= state_s;
      counter_r   <= counter_s;
      hit_latch_r <= hit_latch_s;
      hits_r      <= hits_s;
      trapped_r   <= trapped_s;
      lifelost_r  <= lifelost_s;
      lock_x_r    <= lock_x_s;
      lock_y_r    <= lock_y_s;
    end
  end

  assign trapped       = trapped_r;
  assign lifeLost      = lifelost_r;
  assign trapHits      = hits_r;
  assign trap_if.lockX = lock_x_r;
  assign trap_if.lockY = lock_y_r;

endmodule

// File: tb/tb_trap_capture.sv
module tb_trap_capture;

  typedef struct packed {
    logic        sof;
    logic        col;
    logic        pau;
    logic        rl;
    logic [10:0] cx;
    logic [10:0] cy;
  } in_t;

  typedef struct packed {
    logic        tr;
    logic [10:0] lx;
    logic [10:0] ly;
    logic        ll;
    logic [3:0]  hits;
  } exp_t;

  typedef struct packed {
    in_t  vin;
    exp_t vexp;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        reset_level;
  logic        pause;
  logic        collision;
  logic        trapped;
  logic        lifeLost;
  logic [3:0]  trapHits;
  logic [10:0] cx_v;
  logic [10:0] cy_v;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  vec_t vecs[0:16];

  trap_capture_if tif();
  assign tif.trapCenterX = cx_v;
  assign tif.trapCenterY = cy_v;

  trap_capture #(
    .HOLD_FRAMES    (3),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .reset_level (reset_level),
    .pause       (pause),
    .collision   (collision),
    .trap_if     (tif),
    .trapped     (trapped),
    .lifeLost    (lifeLost),
    .trapHits    (trapHits)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic s, c, p, r, input logic [10:0] x, y,
                              input logic tr, input logic [10:0] lx, ly,
                              input logic ll, input logic [3:0] h);
    vec_t v;
    v.vin  = '{sof: s, col: c, pau: p, rl: r, cx: x, cy: y};
    v.vexp = '{tr: tr, lx: lx, ly: ly, ll: ll, hits: h};
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input in_t vin, input exp_t vexp, input string name);
    exp_t e;
    startOfFrame = vin.sof;
    collision    = vin.col;
    pause        = vin.pau;
    reset_level  = vin.rl;
    cx_v         = vin.cx;
    cy_v         = vin.cy;
    exp_q.push_back(vexp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".trapped"},  32'(trapped),   32'(e.tr));
      chk({name, ".lockX"},    32'(tif.lockX), 32'(e.lx));
      chk({name, ".lockY"},    32'(tif.lockY), 32'(e.ly));
      chk({name, ".lifeLost"}, 32'(lifeLost),  32'(e.ll));
      chk({name, ".trapHits"}, 32'(trapHits),  32'(e.hits));
    end
  endtask

  // One cycle with the current trap centre; lock is expected to equal the
  // centre while trapped and zero otherwise.
  task automatic cyc(input logic s, c, p, r, input logic etr, ell,
                     input logic [3:0] eh, input string name);
    in_t  vi;
    exp_t ve;
    vi = '{sof: s, col: c, pau: p, rl: r, cx: cx_v, cy: cy_v};
    ve = '{tr: etr, lx: (etr ? cx_v : 11'd0), ly: (etr ? cy_v : 11'd0), ll: ell, hits: eh};
    apply(vi, ve, name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".trapped"},  32'(trapped),   32'd0);
    chk({name, ".lockX"},    32'(tif.lockX), 32'd0);
    chk({name, ".lockY"},    32'(tif.lockY), 32'd0);
    chk({name, ".lifeLost"}, 32'(lifeLost),  32'd0);
    chk({name, ".trapHits"}, 32'(trapHits),  32'd0);
  endtask

  task automatic async_reset(input string name);
    startOfFrame = 1'b0;
    collision    = 1'b0;
    pause        = 1'b0;
    reset_level  = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    chk_all_zero(name);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] h;

    // Capture/release/cooldown walk with a trap centre stepping each frame.
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 11'd100, 11'd200, 1'b0, 11'd0,   11'd0,   1'b0, 4'd0);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 11'd100, 11'd200, 1'b0, 11'd0,   11'd0,   1'b0, 4'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 11'd100, 11'd200, 1'b0, 11'd0,   11'd0,   1'b0, 4'd0);
    vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 11'd100, 11'd200, 1'b1, 11'd100, 11'd200, 1'b0, 4'd1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 11'd101, 11'd201, 1'b1, 11'd101, 11'd201, 1'b0, 4'd1);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 11'd101, 11'd201, 1'b1, 11'd101, 11'd201, 1'b0, 4'd1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 11'd102, 11'd202, 1'b1, 11'd102, 11'd202, 1'b0, 4'd1);
    vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 11'd102, 11'd202, 1'b1, 11'd102, 11'd202, 1'b0, 4'd1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 11'd103, 11'd203, 1'b1, 11'd103, 11'd203, 1'b0, 4'd1);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b1, 4'd1);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b0, 4'd1);
    vecs[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b0, 4'd1);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b0, 4'd1);
    vecs[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b0, 4'd1);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b0, 4'd1);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 11'd103, 11'd203, 1'b0, 11'd0,   11'd0,   1'b0, 4'd1);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 11'd50,  11'd60,  1'b1, 11'd50,  11'd60,  1'b0, 4'd2);

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    reset_level  = 1'b0;
    pause        = 1'b0;
    collision    = 1'b0;
    cx_v         = 11'd0;
    cy_v         = 11'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    resetN = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].vin, vecs[i].vexp, $sformatf("vec%0d", i));
    end

    // Pause for 5 frames while held; the hold then completes on the third
    // unpaused frame pulse.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, "pause_sof");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, "pause_gap");
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, "unpaused_f1");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, "unpaused_gap");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, "unpaused_f2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, "unpaused_gap");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, "unpaused_release");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, "pause_cool_entry");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, "pause_cool_f1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, "pause_cool_f2");
    // A collision while paused in IDLE must not be remembered.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, "paused_collision");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, "paused_col_no_cap");

    // Level restart on the same cycle as the releasing frame pulse.
    cx_v = 11'd300;
    cy_v = 11'd400;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, "rl_capture");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, "rl_f1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, "rl_f2");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "rl_with_sof");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rl_no_lifelost");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, "rl_with_collision");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "rl_latch_cleared");

    // 16 full capture/release rounds: the capture count stops at 15.
    for (int i = 0; i < 16; i++) begin
      h    = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      cx_v = 11'(i * 7);
      cy_v = 11'(i * 5 + 1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, h, $sformatf("sat%0d_cap", i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, h, $sformatf("sat%0d_f1", i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, h, $sformatf("sat%0d_f2", i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, h, $sformatf("sat%0d_rel", i));
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h, $sformatf("sat%0d_cool", i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h, $sformatf("sat%0d_c1", i));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h, $sformatf("sat%0d_c2", i));
    end

    // Async reset in the middle of cooldown, then a normal capture.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, "rst_cap");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, "rst_f1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, "rst_f2");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, "rst_rel");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, "rst_cool");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, "rst_cool_f1");
    async_reset("rst_in_cooldown");
    cx_v = 11'd77;
    cy_v = 11'd88;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "post_rst_col");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "post_rst_cap");

    // Async reset while held: everything clears and no release pulse follows.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, "held_f1");
    async_reset("rst_in_captured");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, $sformatf("after_rst_f%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_capture.md
TRAP_CAPTURE -- requirements
Module: trap_capture

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 60, the number of frames the ball is held in the trap; legal range 1..255.
REQ-002 SHALL have parameter COOLDOWN_FRAMES, default 30, the number of frames after release during which collisions are ignored; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port startOfFrame  input  1  one-cycle frame pulse.
REQ-006 SHALL have port reset_level  input  1  synchronous level restart.
REQ-007 SHALL have port pause  input  1  freezes all progress while high.
REQ-008 SHALL have port collision  input  1  pixel-level ball/trap overlap, valid any cycle during scan.
REQ-009 SHALL have port trapCenterX  input  11  current trap centre X from the trap mover.
REQ-010 SHALL have port trapCenterY  input  11  current trap centre Y from the trap mover.
REQ-011 SHALL have port trapped  output  1  high while the ball is held.
REQ-012 SHALL have port lockX  output  11  ball override X, which is the trap centre while trapped and 0 otherwise.
REQ-013 SHALL have port lockY  output  11  ball override Y, which is the trap centre while trapped and 0 otherwise.
REQ-014 SHALL have port lifeLost  output  1  one-cycle pulse on release.
REQ-015 SHALL have port trapHits  output  4  saturating count of captures in the current level.

Function
REQ-016 SHALL implement FSM states IDLE, CAPTURED, RELEASE, COOLDOWN with an 8-bit frame counter.
REQ-017 SHALL, in IDLE with pause low, set hitLatch in any cycle where collision=1.
REQ-018 SHALL, on startOfFrame with pause low in IDLE, go to CAPTURED when hitLatch=1 or collision=1, load counter=HOLD_FRAMES-1, and clear hitLatch; otherwise it SHALL clear hitLatch and stay in IDLE.
REQ-019 SHALL, on entry to CAPTURED, increment trapHits, saturating at 15.
REQ-020 SHALL, in CAPTURED on startOfFrame with pause low, go to RELEASE if counter=0, else decrement counter.
REQ-021 SHALL hold RELEASE for exactly one cycle, assert lifeLost in that cycle, then go to COOLDOWN with counter=COOLDOWN_FRAMES-1.
REQ-022 SHALL, in COOLDOWN on startOfFrame with pause low, go to IDLE if counter=0, else decrement counter.
REQ-023 SHALL ignore collision in CAPTURED, RELEASE, COOLDOWN, and whenever pause=1.
REQ-024 SHALL freeze state and counter while pause=1; RELEASE SHALL still complete regardless of pause, so lifeLost is never lost.
REQ-025 SHALL register all outputs; trapped=1 in CAPTURED only.
REQ-026 SHALL drive lockX/lockY as trapCenterX/Y registered one cycle, so the held ball tracks the moving trap.
REQ-027 SHALL give reset_level priority over all other inputs: go to IDLE, clear hitLatch, counter, trapHits, trapped, and lockX/lockY; lifeLost=0 that cycle.
REQ-028 SHALL produce a captured ball's held duration of exactly HOLD_FRAMES startOfFrame pulses, measured from the capture frame pulse to the release frame pulse.

Reset
REQ-029 SHALL, on resetN low, asynchronously set state=IDLE, counter=0, hitLatch=0, trapped=0, lockX=0, lockY=0, lifeLost=0, trapHits=0.
REQ-030 SHALL, when resetN deasserts mid-capture, resume from IDLE with no lifeLost pulse.

Structure
REQ-031 SHALL define SCREEN_MAIN_TRAP_HOLD_FRAMES and SCREEN_MAIN_TRAP_COOLDOWN_FRAMES in the shared defines package, and the parameter defaults SHALL equal those constants.
REQ-032 SHALL define the FSM state enum locally in the module, not in the package.
REQ-033 SHALL be a single module with no sub-modules; the frame counter is inline.

Verification (HOLD_FRAMES=3, COOLDOWN_FRAMES=2)
REQ-034 SHALL cover: collision=1 for one cycle mid-frame, then startOfFrame -> trapped=1 next cycle; trapHits=1; lockX/Y follow trapCenter stepping +1 per frame.
REQ-035 SHALL cover: after capture, 3 startOfFrame pulses -> trapped=0 after the 3rd, lifeLost=1 for exactly one cycle, and collision during the next 2 frames produces no capture.
REQ-036 SHALL cover: pause=1 for 5 frames while CAPTURED -> trapped stays 1, and release occurs 3 unpaused frames after capture.
REQ-037 SHALL cover: reset_level and startOfFrame asserted in the same cycle while CAPTURED -> IDLE, trapHits=0, lockX=lockY=0, no lifeLost.
REQ-038 SHALL cover: 16 capture/release cycles -> trapHits saturates at 15.
REQ-039 SHALL cover: resetN pulsed low mid-COOLDOWN -> all outputs 0 immediately, and a collision in the next frame captures normally.
